// File: rtl/tcdm_bank_amo_adapter.sv
// TCDM bank adapter: valid/ready requests to one single-port SRAM bank, AMO read-modify-write, LR/SC.
// Latency: read/AMO/LR 2 cycles, write/SC 1 cycle; in_ready drops when response credits run out.
module tcdm_bank_amo_adapter #(
    parameter int DataWidth   = 32,
    parameter int AddrWidth   = 8,
    parameter int MetaWidth   = 16,
    parameter int CoreIdWidth = 2,
    parameter int RespDepth   = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [AddrWidth-1:0]     in_addr_i,
    input  logic                     in_wen_i,
    input  logic [DataWidth/8-1:0]   in_be_i,
    input  logic [3:0]               in_amo_i,
    input  logic [DataWidth-1:0]     in_data_i,
    input  logic [CoreIdWidth-1:0]   in_core_i,
    input  logic [MetaWidth-1:0]     in_meta_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [DataWidth-1:0]     out_data_o,
    output logic [MetaWidth-1:0]     out_meta_o,
    output logic                     mem_req_o,
    output logic                     mem_we_o,
    output logic [AddrWidth-1:0]     mem_addr_o,
    output logic [DataWidth-1:0]     mem_wdata_o,
    output logic [DataWidth/8-1:0]   mem_be_o,
    input  logic [DataWidth-1:0]     mem_rdata_i
);
    localparam int PtrWidth = (RespDepth > 1) ? $clog2(RespDepth) : 1;
    localparam int CntWidth = $clog2(RespDepth + 1) + 1;

    typedef enum logic {IDLE, AMO_WB} state_t;
    state_t state;

    logic                   inflight, pend_amo;
    logic [3:0]             pend_op;
    logic [DataWidth-1:0]   pend_operand;
    logic [AddrWidth-1:0]   pend_addr;
    logic [MetaWidth-1:0]   pend_meta;

    logic                   rsv_vld;
    logic [AddrWidth-1:0]   rsv_addr;
    logic [CoreIdWidth-1:0] rsv_core;

    logic [DataWidth-1:0]   fifo_data [RespDepth];
    logic [MetaWidth-1:0]   fifo_meta [RespDepth];
    logic [PtrWidth-1:0]    wr_ptr, rd_ptr, imm_idx;
    logic [CntWidth-1:0]    fifo_count, occ;

    logic [3:0]             op_eff;
    logic                   is_plain, is_amo, is_lr, is_sc, sc_ok, accept;
    logic                   wr_now, rd_now, push_rd, push_imm, pop;
    logic [DataWidth-1:0]   imm_data, amo_result;

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
        return (p == PtrWidth'(RespDepth - 1)) ? '0 : p + PtrWidth'(1);
    endfunction

    // Opcodes C..F decode as "no AMO".
    assign op_eff   = (in_amo_i >= 4'hC) ? 4'h0 : in_amo_i;
    assign is_plain = (op_eff == 4'h0);
    assign is_amo   = (op_eff >= 4'h1) && (op_eff <= 4'h9);
    assign is_lr    = (op_eff == 4'hA);
    assign is_sc    = (op_eff == 4'hB);
    assign sc_ok    = rsv_vld && (rsv_addr == in_addr_i) && (rsv_core == in_core_i);

    assign occ        = fifo_count + CntWidth'(inflight);
    assign in_ready_o = !rst_i && (state == IDLE) && (occ < CntWidth'(RespDepth));
    assign accept     = in_valid_i && in_ready_o;

    assign wr_now   = accept && ((is_plain && in_wen_i) || (is_sc && sc_ok));
    assign rd_now   = accept && ((is_plain && !in_wen_i) || is_amo || is_lr);
    assign push_rd  = inflight;
    assign push_imm = accept && ((is_plain && in_wen_i) || is_sc);
    assign imm_data = {{(DataWidth-1){1'b0}}, is_sc && !sc_ok};
    assign pop      = out_valid_o && out_ready_i;

    always_comb begin
        amo_result = pend_operand;
        case (pend_op)
            4'd2:    amo_result = mem_rdata_i + pend_operand;
            4'd3:    amo_result = mem_rdata_i & pend_operand;
            4'd4:    amo_result = mem_rdata_i | pend_operand;
            4'd5:    amo_result = mem_rdata_i ^ pend_operand;
            4'd6:    amo_result = ($signed(mem_rdata_i) > $signed(pend_operand)) ? mem_rdata_i : pend_operand;
            4'd7:    amo_result = (mem_rdata_i > pend_operand) ? mem_rdata_i : pend_operand;
            4'd8:    amo_result = ($signed(mem_rdata_i) < $signed(pend_operand)) ? mem_rdata_i : pend_operand;
            4'd9:    amo_result = (mem_rdata_i < pend_operand) ? mem_rdata_i : pend_operand;
            default: amo_result = pend_operand;
        endcase
    end

    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_be_o    = '0;
        if (state == AMO_WB) begin
            mem_req_o   = 1'b1;
            mem_we_o    = 1'b1;
            mem_addr_o  = pend_addr;
            mem_wdata_o = amo_result;
            mem_be_o    = '1;
        end else if (wr_now || rd_now) begin
            mem_req_o   = 1'b1;
            mem_we_o    = wr_now;
            mem_addr_o  = in_addr_i;
            mem_wdata_o = wr_now ? in_data_i : '0;
            mem_be_o    = is_plain ? in_be_i : '1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            inflight     <= 1'b0;
            pend_amo     <= 1'b0;
            pend_op      <= '0;
            pend_operand <= '0;
            pend_addr    <= '0;
            pend_meta    <= '0;
            rsv_vld      <= 1'b0;
            rsv_addr     <= '0;
            rsv_core     <= '0;
        end else begin
            state    <= (rd_now && is_amo) ? AMO_WB : IDLE;
            inflight <= rd_now;
            if (rd_now) begin
                pend_amo     <= is_amo;
                pend_op      <= is_amo ? op_eff : 4'h0;
                pend_operand <= in_data_i;
                pend_addr    <= in_addr_i;
                pend_meta    <= in_meta_i;
            end
            // Reservation is resolved entirely in the accept cycle.
            if (accept) begin
                if (is_lr) begin
                    rsv_vld  <= 1'b1;
                    rsv_addr <= in_addr_i;
                    rsv_core <= in_core_i;
                end else if (is_sc && sc_ok) begin
                    rsv_vld <= 1'b0;
                end else if (((is_plain && in_wen_i) || is_amo) && (rsv_addr == in_addr_i)) begin
                    rsv_vld <= 1'b0;
                end
            end
        end
    end

    // A read completing and a write accepted in the same cycle push two entries, read first.
    assign imm_idx = push_rd ? ptr_inc(wr_ptr) : wr_ptr;

    always_ff @(posedge clk_i) begin
        if (push_rd) begin
            fifo_data[wr_ptr] <= mem_rdata_i;
            fifo_meta[wr_ptr] <= pend_meta;
        end
        if (push_imm) begin
            fifo_data[imm_idx] <= imm_data;
            fifo_meta[imm_idx] <= in_meta_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push_rd && push_imm)
                wr_ptr <= ptr_inc(ptr_inc(wr_ptr));
            else if (push_rd || push_imm)
                wr_ptr <= ptr_inc(wr_ptr);
            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);
            fifo_count <= fifo_count + CntWidth'(push_rd) + CntWidth'(push_imm) - CntWidth'(pop);
        end
    end

    assign out_valid_o = (fifo_count != '0);
    assign out_data_o  = out_valid_o ? fifo_data[rd_ptr] : '0;
    assign out_meta_o  = out_valid_o ? fifo_meta[rd_ptr] : '0;

    logic unused_pend_amo;
    assign unused_pend_amo = pend_amo;

endmodule

// File: tb/tb_tcdm_bank_amo_adapter.sv
// Randomized and directed bench for tcdm_bank_amo_adapter with an SRAM model and a reference scoreboard.
module tb_tcdm_bank_amo_adapter;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_wen, out_valid, out_ready;
    logic [7:0]  in_addr, mem_addr;
    logic [3:0]  in_be, in_amo, mem_be;
    logic [31:0] in_data, out_data, mem_wdata, mem_rdata;
    logic [1:0]  in_core;
    logic [15:0] in_meta, out_meta;
    logic        mem_req, mem_we;

    tcdm_bank_amo_adapter #(.DataWidth(32), .AddrWidth(8), .MetaWidth(16),
                            .CoreIdWidth(2), .RespDepth(2)) dut (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_addr_i(in_addr),
        .in_wen_i(in_wen), .in_be_i(in_be), .in_amo_i(in_amo), .in_data_i(in_data),
        .in_core_i(in_core), .in_meta_i(in_meta),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
        .out_meta_o(out_meta),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_be_o(mem_be), .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    // SRAM bank model, 1-cycle read latency, cleared while reset is held.
    logic [31:0] bank [256];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) bank[i] <= 32'h0;
        end else if (mem_req) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) bank[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= bank[mem_addr];
            end
        end
    end

    int vectors = 0, miscompares = 0, n_resp = 0;
    logic [31:0] ref_mem [256];
    logic        rsv_v;
    logic [7:0]  rsv_a;
    logic [1:0]  rsv_c;
    logic [31:0] exp_d [$];
    logic [15:0] exp_m [$];
    bit          last_acc, wb_pending;
    logic [7:0]  wb_addr;
    logic [31:0] wb_data;

    function automatic logic [31:0] amo_ref(input int op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            1: return b;
            2: return a + b;
            3: return a & b;
            4: return a | b;
            5: return a ^ b;
            6: return ($signed(a) > $signed(b)) ? a : b;
            7: return (a > b) ? a : b;
            8: return ($signed(a) < $signed(b)) ? a : b;
            default: return (a < b) ? a : b;
        endcase
    endfunction

    task automatic reset_model();
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
        rsv_v = 1'b0; rsv_a = 8'h0; rsv_c = 2'h0;
        exp_d.delete(); exp_m.delete();
        wb_pending = 0;
    endtask

    task automatic model_accept();
        int op;
        bit exp_req, exp_we;
        logic [31:0] old;
        op = (in_amo >= 4'hC) ? 0 : int'(in_amo);
        exp_req = 1; exp_we = 0;
        if (op == 0) begin
            if (in_wen) begin
                exp_we = 1;
                for (int b = 0; b < 4; b++)
                    if (in_be[b]) ref_mem[in_addr][8*b +: 8] = in_data[8*b +: 8];
                if (rsv_v && rsv_a == in_addr) rsv_v = 0;
                exp_d.push_back(32'h0);
            end else begin
                exp_d.push_back(ref_mem[in_addr]);
            end
        end else if (op <= 9) begin
            old = ref_mem[in_addr];
            ref_mem[in_addr] = amo_ref(op, old, in_data);
            if (rsv_v && rsv_a == in_addr) rsv_v = 0;
            exp_d.push_back(old);
            wb_pending = 1; wb_addr = in_addr; wb_data = ref_mem[in_addr];
        end else if (op == 10) begin
            exp_d.push_back(ref_mem[in_addr]);
            rsv_v = 1; rsv_a = in_addr; rsv_c = in_core;
        end else begin
            if (rsv_v && rsv_a == in_addr && rsv_c == in_core) begin
                exp_we = 1;
                ref_mem[in_addr] = in_data;
                rsv_v = 0;
                exp_d.push_back(32'h0);
            end else begin
                exp_req = 0;
                exp_d.push_back(32'h1);
            end
        end
        exp_m.push_back(in_meta);
        vectors++;
        if (mem_req !== exp_req || (exp_req && (mem_addr !== in_addr || mem_we !== exp_we))) begin
            miscompares++;
            $display("FAIL accept_access: req/we/addr %b/%b/%h want %b/%b/%h",
                     mem_req, mem_we, mem_addr, exp_req, exp_we, in_addr);
        end
    endtask

    // One cycle: sample at negedge+1, update models, advance to next negedge.
    task automatic step();
        logic [31:0] d;
        logic [15:0] m;
        #1;
        last_acc = 0;
        if (wb_pending) begin
            wb_pending = 0;
            vectors++;
            if (in_ready !== 1'b0 || mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== wb_addr ||
                mem_wdata !== wb_data || mem_be !== 4'hF) begin
                miscompares++;
                $display("FAIL amo_writeback: rdy=%b req=%b we=%b addr=%h wdata=%h be=%h want rdy=0 1/1/%h/%h/f",
                         in_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_be, wb_addr, wb_data);
            end
        end
        if (out_valid && out_ready) begin
            n_resp++;
            vectors++;
            if (exp_d.size() == 0) begin
                miscompares++;
                $display("FAIL resp_extra: got %h/%h with nothing expected", out_data, out_meta);
            end else begin
                d = exp_d.pop_front();
                m = exp_m.pop_front();
                if (out_data !== d || out_meta !== m) begin
                    miscompares++;
                    $display("FAIL resp: data/meta %h/%h want %h/%h", out_data, out_meta, d, m);
                end
            end
        end
        if (in_valid && in_ready) begin
            last_acc = 1;
            model_accept();
        end
        @(negedge clk);
    endtask

    task automatic req(input logic [7:0] a, input logic w, input logic [3:0] be, input logic [3:0] amo,
                       input logic [31:0] d, input logic [1:0] c, input logic [15:0] m);
        in_addr = a; in_wen = w; in_be = be; in_amo = amo; in_data = d; in_core = c; in_meta = m;
        in_valid = 1;
        for (int i = 0; i < 50; i++) begin
            step();
            if (last_acc) break;
        end
        in_valid = 0;
        vectors++;
        if (!last_acc) begin
            miscompares++;
            $display("FAIL req_timeout: request at %h not accepted, want accept", a);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && (exp_d.size() != 0 || wb_pending); i++) step();
        vectors++;
        if (exp_d.size() != 0) begin
            miscompares++;
            $display("FAIL drain_timeout: %0d responses outstanding, want 0", exp_d.size());
        end
    endtask

    task automatic test_reset();
        rst = 1; in_valid = 1; in_addr = 8'h5A; in_wen = 1; in_be = 4'hF; in_amo = 4'h0;
        in_data = 32'hCAFE0001; in_core = 2'd1; in_meta = 16'h1234; out_ready = 1;
        repeat (3) @(negedge clk);
        #1;
        vectors++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 32'h0 || out_meta !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_resp: rdy=%b vld=%b data=%h meta=%h want all 0", in_ready, out_valid, out_data, out_meta);
        end
        vectors++;
        if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 8'h0 || mem_wdata !== 32'h0 || mem_be !== 4'h0) begin
            miscompares++;
            $display("FAIL reset_mem: req=%b we=%b addr=%h wdata=%h be=%h want all 0", mem_req, mem_we, mem_addr, mem_wdata, mem_be);
        end
        in_valid = 0;
        @(negedge clk);
        rst = 0;
        reset_model();
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready: got %b want 1", in_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_read();
        req(8'h10, 1, 4'hF, 4'h0, 32'hDEADBEEF, 2'd0, 16'h0001);
        drain();
        in_addr = 8'h10; in_wen = 0; in_be = 4'hF; in_amo = 4'h0; in_meta = 16'h0042; in_valid = 1;
        step();
        in_valid = 0;
        vectors++;
        if (!last_acc) begin miscompares++; $display("FAIL read_accept: got 0 want 1"); end
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL read_lat_t1: valid %b want 0", out_valid); end
        @(negedge clk);
        #1;
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 32'hDEADBEEF || out_meta !== 16'h0042) begin
            miscompares++;
            $display("FAIL read_lat_t2: vld/data/meta %b/%h/%h want 1/deadbeef/0042", out_valid, out_data, out_meta);
        end
        step();
        drain();
    endtask

    task automatic test_write_be();
        req(8'h05, 1, 4'b0011, 4'h0, 32'h12345678, 2'd0, 16'h0005);
        #1;
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 32'h0) begin
            miscompares++;
            $display("FAIL write_resp_t1: vld/data %b/%h want 1/0", out_valid, out_data);
        end
        step();
        req(8'h05, 0, 4'hF, 4'h0, 32'h0, 2'd0, 16'h0006);
        drain();
        vectors++;
        if (bank[8'h05] !== 32'h00005678) begin
            miscompares++;
            $display("FAIL write_be_bank: got %h want 00005678", bank[8'h05]);
        end
    endtask

    task automatic test_amo();
        req(8'h30, 1, 4'hF, 4'h0, 32'hFFFFFFFF, 2'd0, 16'h0030);
        req(8'h31, 1, 4'hF, 4'h0, 32'h80000000, 2'd0, 16'h0031);
        req(8'h32, 1, 4'hF, 4'h0, 32'h80000000, 2'd0, 16'h0032);
        drain();
        req(8'h30, 0, 4'h0, 4'h2, 32'h00000001, 2'd0, 16'hA002);
        req(8'h31, 1, 4'h1, 4'h6, 32'h00000005, 2'd0, 16'hA006);
        req(8'h32, 0, 4'h0, 4'h7, 32'h00000005, 2'd0, 16'hA007);
        req(8'h30, 0, 4'hF, 4'h0, 32'h0, 2'd0, 16'hB030);
        drain();
        vectors++;
        if (bank[8'h30] !== 32'h0 || bank[8'h31] !== 32'h5 || bank[8'h32] !== 32'h80000000) begin
            miscompares++;
            $display("FAIL amo_bank: %h/%h/%h want 00000000/00000005/80000000", bank[8'h30], bank[8'h31], bank[8'h32]);
        end
    endtask

    task automatic test_lrsc();
        req(8'h20, 0, 4'hF, 4'hA, 32'h0, 2'd1, 16'hC001);
        req(8'h20, 0, 4'hF, 4'hB, 32'h7, 2'd1, 16'hC002);
        req(8'h20, 0, 4'hF, 4'hB, 32'h8, 2'd1, 16'hC003);
        drain();
        vectors++;
        if (bank[8'h20] !== 32'h7) begin miscompares++; $display("FAIL sc_bank: got %h want 00000007", bank[8'h20]); end
        req(8'h20, 0, 4'hF, 4'hA, 32'h0, 2'd0, 16'hC004);
        req(8'h20, 1, 4'hF, 4'h0, 32'h0000ABCD, 2'd2, 16'hC005);
        req(8'h20, 0, 4'hF, 4'hB, 32'h9, 2'd0, 16'hC006);
        drain();
        vectors++;
        if (bank[8'h20] !== 32'h0000ABCD) begin miscompares++; $display("FAIL sc_cleared_bank: got %h want 0000abcd", bank[8'h20]); end
    endtask

    task automatic test_backpressure();
        int k, r0;
        logic [7:0] addrs [4];
        addrs[0] = 8'h10; addrs[1] = 8'h05; addrs[2] = 8'h30; addrs[3] = 8'h31;
        k = 0; r0 = n_resp;
        out_ready = 0;
        in_wen = 0; in_be = 4'hF; in_amo = 4'h0; in_core = 2'd0; in_data = 32'h0;
        for (int c = 0; c < 8; c++) begin
            in_valid = (k < 4);
            if (k < 4) begin in_addr = addrs[k]; in_meta = 16'h0100 + 16'(k); end
            step();
            if (last_acc) k++;
        end
        #1;
        vectors++;
        if (k != 2 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_stall: accepted %0d rdy %b want 2 and 0", k, in_ready);
        end
        out_ready = 1;
        for (int c = 0; c < 100 && !(k == 4 && exp_d.size() == 0); c++) begin
            in_valid = (k < 4);
            if (k < 4) begin in_addr = addrs[k]; in_meta = 16'h0100 + 16'(k); end
            step();
            if (last_acc) k++;
        end
        in_valid = 0;
        vectors++;
        if (k != 4 || n_resp - r0 != 4) begin
            miscompares++;
            $display("FAIL bp_drain: accepted %0d responses %0d want 4 and 4", k, n_resp - r0);
        end
    endtask

    task automatic test_reset_mid_amo();
        out_ready = 0;
        req(8'h44, 1, 4'hF, 4'h0, 32'h11, 2'd0, 16'hD001);
        req(8'h44, 0, 4'h0, 4'h2, 32'h5, 2'd0, 16'hD002);
        rst = 1;
        #1;
        vectors++;
        if (mem_req !== 1'b0 || mem_we !== 1'b0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_amo: req/we/vld %b/%b/%b want 0/0/0", mem_req, mem_we, out_valid);
        end
        repeat (2) @(negedge clk);
        rst = 0;
        reset_model();
        out_ready = 1;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid_amo_after: vld/rdy %b/%b want 0/1", out_valid, in_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        bit have = 0;
        for (int c = 0; c < 2000; c++) begin
            if (!have && $urandom_range(0, 3) != 0) begin
                in_addr = 8'h40 + 8'($urandom_range(0, 3));
                in_wen  = 1'($urandom);
                in_be   = 4'($urandom);
                in_amo  = 4'($urandom);
                in_data = $urandom;
                in_core = 2'($urandom_range(0, 1));
                in_meta = 16'($urandom);
                have = 1;
            end
            in_valid  = have;
            out_ready = ($urandom_range(0, 3) != 0);
            step();
            if (last_acc) have = 0;
        end
        in_valid = 0;
        out_ready = 1;
        drain();
        step();
        for (int a = 8'h40; a < 8'h44; a++) begin
            vectors++;
            if (bank[a] !== ref_mem[a]) begin
                miscompares++;
                $display("FAIL rand_bank[%h]: got %h want %h", a, bank[a], ref_mem[a]);
            end
        end
    endtask

    initial begin
        rst = 1; in_valid = 0; in_addr = 0; in_wen = 0; in_be = 0; in_amo = 0;
        in_data = 0; in_core = 0; in_meta = 0; out_ready = 1;
        reset_model();
        @(negedge clk);
        test_reset();
        test_read();
        test_write_be();
        test_amo();
        test_lrsc();
        test_backpressure();
        test_reset_mid_amo();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/tcdm_bank_amo_adapter.md
Name: tcdm_bank_amo_adapter

Overview:
- Sits between the tile-level TCDM slave interconnect (tcdm_slave_req_t / tcdm_slave_resp_t) and one single-port SRAM bank (TCDMSizePerBank bytes, 1-cycle read latency).
- Translates valid/ready requests into bank accesses and executes atomic operations as read-modify-write.
- Implements LR/SC with a single reservation.
- Returns exactly one response per request, in order, through a credit-guarded response FIFO.

Parameters:
- DataWidth, 32, word width (bits).
- AddrWidth, 8, bank word-address width (TCDMAddrMemWidth).
- MetaWidth, 16, opaque tag width (meta_id, core_id and ini_addr concatenated), returned unchanged.
- CoreIdWidth, 2, width of the requesting-core id used for the reservation.
- RespDepth, 2, response FIFO depth (≥2).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; one clock domain, asynchronous, active-high.
- in_valid_i  in  1  request valid.
- in_ready_o  out  1  request accepted when valid&&ready.
- in_addr_i  in  AddrWidth  bank word address.
- in_wen_i  in  1  1 = write.
- in_be_i  in  DataWidth/8  byte enables.
- in_amo_i  in  4  atomic opcode.
- in_data_i  in  DataWidth  write data / AMO operand.
- in_core_i  in  CoreIdWidth  requesting core.
- in_meta_i  in  MetaWidth  opaque tag.
- out_valid_o  out  1  response valid.
- out_ready_i  in  1  response consumed.
- out_data_o  out  DataWidth  response data.
- out_meta_o  out  MetaWidth  tag of the request.
- mem_req_o  out  1  bank access.
- mem_we_o  out  1  bank write.
- mem_addr_o  out  AddrWidth  bank address.
- mem_wdata_o  out  DataWidth  bank write data.
- mem_be_o  out  DataWidth/8  bank byte enables.
- mem_rdata_i  in  DataWidth  bank read data, valid the cycle after a read.

Behaviour:
- Reset values:
  - All outputs 0.
  - FSM in IDLE; FIFO empty; reservation invalid; credits = RespDepth.
  - Reset mid-AMO aborts the pending write-back and discards FIFO contents.
- AMO opcodes:
  - 0 none, 1 swap, 2 add, 3 and, 4 or, 5 xor, 6 max, 7 maxu, 8 min, 9 minu, A LR, B SC.
  - C–F are treated as 0.
  - For AMOs and LR/SC, in_be_i and in_wen_i are ignored; operations are full-word.
- in_ready_o = (state==IDLE) && (fifo_count + inflight < RespDepth).
  - inflight = 1 while an accepted read/AMO/LR awaits rdata.
  - A pop in the same cycle does not free a credit until the next cycle.
- Accept in cycle T: mem_req_o=1 in T with mem_addr_o=in_addr_i (combinational).
- Plain read: mem_we_o=0. rdata pushed at end of T+1; out_valid_o from T+2. Latency 2.
- Plain write: mem_we_o=1 with data/be. Response data 0 pushed at end of T; out_valid_o from T+1.
- AMO 1–9, cycle T: read.
  - FSM goes to AMO_WB for T+1.
  - In T+1: mem_req_o=mem_we_o=1, same address, be all ones, wdata = op(old=mem_rdata_i, operand).
  - Response data = old value, pushed end of T+1.
  - in_ready_o=0 in T+1; FSM returns to IDLE.
- AMO arithmetic:
  - add wraps modulo 2^DataWidth.
  - max/min compare signed; maxu/minu compare unsigned.
- LR: behaves as a read; sets reservation {valid=1, addr, core}.
- SC, evaluated at T:
  - If reservation valid and addr and core match: write full word, response 0, reservation cleared.
  - Otherwise: no bank access (mem_req_o=0), response 1, reservation unchanged.
  - Latency as a plain write.
- Any plain write or AMO 1–9 to the reserved address, from any core, clears the reservation in the accept cycle.
- A new LR overwrites the reservation.
- Response FIFO:
  - FIFO order equals accept order.
  - Push and pop in the same cycle are allowed when full; the count is unchanged.
  - The FIFO never overflows, by construction of the credits.
  - out_meta_o returns in_meta_i of the corresponding request.
- Back-pressure: out_ready_i=0 holds out_valid_o/out_data_o/out_meta_o stable. Once credits are exhausted, in_ready_o drops.

Test Plan:
- Read addr 0x10 holding 0xDEADBEEF, meta 0x0042 -> mem_req_o in T, out_valid_o in T+2 with data 0xDEADBEEF and meta 0x0042.
- Write 0x12345678 with be=0b0011 to 0x05, then read 0x05 (initially 0) -> write response 0 at T+1; read returns 0x00005678.
- AMO add operand 0x00000001 on word 0xFFFFFFFF -> response 0xFFFFFFFF; bank holds 0x00000000; in_ready_o low in T+1. AMO max operand 0x00000005 on word 0x80000000 -> response 0x80000000; bank holds 0x00000005. AMO maxu with the same values -> bank unchanged.
- LR core 1 at 0x20, then SC core 1 at 0x20 data 7 -> SC response 0, bank 7. A second SC -> response 1, no write.
- LR core 0 at 0x20, write from core 2 to 0x20, then SC core 0 -> response 1; bank holds the core-2 data.
- out_ready_i=0 with RespDepth=2, issue 4 back-to-back reads -> exactly 2 accepted, then in_ready_o=0. Release out_ready_i -> responses drain in order, the remaining 2 are accepted, and no response is lost or duplicated.
